id_ex_issue_reg: RTL

//  ID->EX pipeline register and issue controller: the driving end of the execute-stage input interface.

---
 rtl/id_ex_issue_reg_if.sv | 45 ++++
 rtl/id_ex_issue_reg.sv | 123 ++++++++++++
 2 files changed

// File: rtl/id_ex_issue_reg_if.sv
// Execute-stage input bundle: decoded ID fields and hazard sources in, registered EX fields out.
// The master modport is the issue register; the slave modport is the surrounding pipeline.
`timescale 1ns/1ps
interface id_ex_issue_reg_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic [XLEN-1:0] IMM_ID, REG_DATA1_ID, REG_DATA2_ID, PC_ID;
    logic [2:0]      FUNCT3_ID;
    logic [6:0]      FUNCT7_ID;
    logic [RA_W-1:0] RD_ID, RS1_ID, RS2_ID;
    logic            RegWrite_ID, MemtoReg_ID, MemRead_ID, MemWrite_ID, ALUSrc_ID, Branch_ID;
    logic [1:0]      ALUop_ID;
    logic [RA_W-1:0] rd_ex, rd_mem;
    logic            RegWrite_ex, MemRead_ex, RegWrite_mem;
    logic            hold, flush;

    logic [XLEN-1:0] IMM_EX, REG_DATA1_EX, REG_DATA2_EX, PC_EX;
    logic [2:0]      FUNCT3_EX;
    logic [6:0]      FUNCT7_EX;
    logic [RA_W-1:0] RD_EX, RS1_EX, RS2_EX;
    logic            RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, ALUSrc_EX, Branch_EX;
    logic [1:0]      ALUop_EX, forwardA, forwardB;
    logic            valid_EX, stall_IF_ID;

    modport master (
        input  IMM_ID, REG_DATA1_ID, REG_DATA2_ID, PC_ID, FUNCT3_ID, FUNCT7_ID,
               RD_ID, RS1_ID, RS2_ID, RegWrite_ID, MemtoReg_ID, MemRead_ID, MemWrite_ID,
               ALUSrc_ID, Branch_ID, ALUop_ID, rd_ex, RegWrite_ex, MemRead_ex,
               rd_mem, RegWrite_mem, hold, flush,
        output IMM_EX, REG_DATA1_EX, REG_DATA2_EX, PC_EX, FUNCT3_EX, FUNCT7_EX,
               RD_EX, RS1_EX, RS2_EX, RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX,
               ALUSrc_EX, Branch_EX, ALUop_EX, forwardA, forwardB, valid_EX, stall_IF_ID
    );

    modport slave (
        output IMM_ID, REG_DATA1_ID, REG_DATA2_ID, PC_ID, FUNCT3_ID, FUNCT7_ID,
               RD_ID, RS1_ID, RS2_ID, RegWrite_ID, MemtoReg_ID, MemRead_ID, MemWrite_ID,
               ALUSrc_ID, Branch_ID, ALUop_ID, rd_ex, RegWrite_ex, MemRead_ex,
               rd_mem, RegWrite_mem, hold, flush,
        input  IMM_EX, REG_DATA1_EX, REG_DATA2_EX, PC_EX, FUNCT3_EX, FUNCT7_EX,
               RD_EX, RS1_EX, RS2_EX, RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX,
               ALUSrc_EX, Branch_EX, ALUop_EX, forwardA, forwardB, valid_EX, stall_IF_ID
    );
endinterface

// File: rtl/id_ex_issue_reg.sv
// ID->EX pipeline register: registers the decoded instruction, precomputes EX forward selects,
// and turns load-use hazards and branch flushes into bubbles.
`timescale 1ns/1ps
module id_ex_issue_reg #(
    parameter int       XLEN      = 32,
    parameter int       RA_W      = 5,
    parameter bit [6:0] NOP_FUNCT = 7'd0
) (
    input logic            clk,
    input logic            reset,
    id_ex_issue_reg_if.master bus
);
    typedef struct packed {
        logic [XLEN-1:0] imm, d1, d2, pc;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [RA_W-1:0] rd, rs1, rs2;
        logic            rw, m2r, mr, mw, alusrc, br;
        logic [1:0]      aluop, fa, fb;
        logic            v;
    } ex_t;

    typedef enum logic [1:0] {SEL_HOLD = 2'd0, SEL_BUBBLE = 2'd1, SEL_LOAD = 2'd2} sel_t;

    ex_t  ex_q, ex_d, id_s, bubble_s;
    sel_t sel_s;
    logic lu_s;

    // rs==0 never forwards; a nonzero rs matching rd also proves rd!=0.
    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs,
                                           input logic [RA_W-1:0] rd_e, input logic rw_e,
                                           input logic [RA_W-1:0] rd_m, input logic rw_m);
        logic [1:0] sel;
        if (rs == {RA_W{1'b0}}) begin
            sel = 2'b00;
        end else if (rw_e && (rd_e == rs)) begin
            sel = 2'b10;
        end else if (rw_m && (rd_m == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Hazard detection, candidate EX contents and the hold/bubble/load select.
    always_comb begin
        lu_s = bus.MemRead_ex && (bus.rd_ex != {RA_W{1'b0}}) &&
               ((bus.rd_ex == bus.RS1_ID) || (bus.rd_ex == bus.RS2_ID));

        bubble_s    = '0;
        bubble_s.f3 = NOP_FUNCT[2:0];
        bubble_s.f7 = NOP_FUNCT;

        id_s        = '0;
        id_s.imm    = bus.IMM_ID;
        id_s.d1     = bus.REG_DATA1_ID;
        id_s.d2     = bus.REG_DATA2_ID;
        id_s.pc     = bus.PC_ID;
        id_s.f3     = bus.FUNCT3_ID;
        id_s.f7     = bus.FUNCT7_ID;
        id_s.rd     = bus.RD_ID;
        id_s.rs1    = bus.RS1_ID;
        id_s.rs2    = bus.RS2_ID;
        id_s.rw     = bus.RegWrite_ID;
        id_s.m2r    = bus.MemtoReg_ID;
        id_s.mr     = bus.MemRead_ID;
        id_s.mw     = bus.MemWrite_ID;
        id_s.alusrc = bus.ALUSrc_ID;
        id_s.br     = bus.Branch_ID;
        id_s.aluop  = bus.ALUop_ID;
        id_s.fa     = fwd_sel(bus.RS1_ID, bus.rd_ex, bus.RegWrite_ex, bus.rd_mem, bus.RegWrite_mem);
        id_s.fb     = fwd_sel(bus.RS2_ID, bus.rd_ex, bus.RegWrite_ex, bus.rd_mem, bus.RegWrite_mem);
        id_s.v      = 1'b1;

        if (bus.hold) begin
            sel_s = SEL_HOLD;
        end else if (bus.flush || lu_s) begin
            sel_s = SEL_BUBBLE;
        end else begin
            sel_s = SEL_LOAD;
        end

        case (sel_s)
            SEL_HOLD:   ex_d = ex_q;
            SEL_BUBBLE: ex_d = bubble_s;
            SEL_LOAD:   ex_d = id_s;
            default:    ex_d = bubble_s;
        endcase
    end

    // EX-stage register; reset leaves an all-zero bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // A flush redirects fetch, so it overrides the stall; nothing stalls during hold or reset.
    assign bus.stall_IF_ID  = lu_s && !bus.flush && !bus.hold && !reset;

    assign bus.IMM_EX       = ex_q.imm;
    assign bus.REG_DATA1_EX = ex_q.d1;
    assign bus.REG_DATA2_EX = ex_q.d2;
    assign bus.PC_EX        = ex_q.pc;
    assign bus.FUNCT3_EX    = ex_q.f3;
    assign bus.FUNCT7_EX    = ex_q.f7;
    assign bus.RD_EX        = ex_q.rd;
    assign bus.RS1_EX       = ex_q.rs1;
    assign bus.RS2_EX       = ex_q.rs2;
    assign bus.RegWrite_EX  = ex_q.rw;
    assign bus.MemtoReg_EX  = ex_q.m2r;
    assign bus.MemRead_EX   = ex_q.mr;
    assign bus.MemWrite_EX  = ex_q.mw;
    assign bus.ALUSrc_EX    = ex_q.alusrc;
    assign bus.Branch_EX    = ex_q.br;
    assign bus.ALUop_EX     = ex_q.aluop;
    assign bus.forwardA     = ex_q.fa;
    assign bus.forwardB     = ex_q.fb;
    assign bus.valid_EX     = ex_q.v;
endmodule
